// File: rtl/extest_sequencer_if.sv
// Host/chain bundle for the EXTEST sequencer: host requests and results plus
// the serial wrapper-chain controls. Signal prefixes are from the sequencer's side.
interface extest_sequencer_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic             i_start;
  logic             i_abort;
  logic [N-1:0]     i_pattern;
  logic [N-1:0]     i_expected;
  logic [N-1:0]     i_mask;
  logic             i_chain_so;

  logic             o_ready;
  logic             o_extest_mode;
  logic             o_shift_en;
  logic             o_update_en;
  logic             o_capture_en;
  logic             o_chain_si;
  logic             o_done;
  logic             o_pass;
  logic [N-1:0]     o_response;
  logic [N-1:0]     o_fail_bits;
  logic [CNT_W-1:0] o_pattern_count;
  logic [CNT_W-1:0] o_fail_count;

  modport slave (
    input  i_start, i_abort, i_pattern, i_expected, i_mask, i_chain_so,
    output o_ready, o_extest_mode, o_shift_en, o_update_en, o_capture_en,
           o_chain_si, o_done, o_pass, o_response, o_fail_bits,
           o_pattern_count, o_fail_count
  );

  modport master (
    output i_start, i_abort, i_pattern, i_expected, i_mask, i_chain_so,
    input  o_ready, o_extest_mode, o_shift_en, o_update_en, o_capture_en,
           o_chain_si, o_done, o_pass, o_response, o_fail_bits,
           o_pattern_count, o_fail_count
  );
endinterface

// File: rtl/extest_sequencer.sv
// Runs one EXTEST pattern per start: serial load, update, capture, serial unload,
// masked compare. All outputs are registered and reflect the state being entered.
module extest_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  extest_sequencer_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UPDATE, S_CAPTURE, S_UNLOAD, S_COMPARE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [N-1:0]     r_pat_sr;
  logic [N-1:0]     r_exp;
  logic [N-1:0]     r_mask;
  logic [N-1:0]     r_resp_sr;
  logic             r_ready;
  logic             r_mode;
  logic             r_shift;
  logic             r_upd;
  logic             r_cap;
  logic             r_si;
  logic             r_done;
  logic             r_pass;
  logic [N-1:0]     r_response;
  logic [N-1:0]     r_fail_bits;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_fcnt;

  logic             w_last;
  logic [N-1:0]     w_fail;

  assign w_last = (r_cnt == CW'(N - 1));
  assign w_fail = (r_resp_sr ^ r_exp) & r_mask;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pat_sr    <= '0;
      r_exp       <= '0;
      r_mask      <= '0;
      r_resp_sr   <= '0;
      r_ready     <= 1'b0;
      r_mode      <= 1'b0;
      r_shift     <= 1'b0;
      r_upd       <= 1'b0;
      r_cap       <= 1'b0;
      r_si        <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_response  <= '0;
      r_fail_bits <= '0;
      r_pcnt      <= '0;
      r_fcnt      <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && bus.i_abort) begin
        // Abort drops the chain controls without touching results or counters
        r_state <= S_IDLE;
        r_ready <= 1'b1;
        r_mode  <= 1'b0;
        r_shift <= 1'b0;
        r_upd   <= 1'b0;
        r_cap   <= 1'b0;
        r_si    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ready <= 1'b1;
            if (bus.i_start && !bus.i_abort) begin
              // chain_si is pre-registered, so the shadow holds the bits after bit 0
              r_pat_sr <= {1'b0, bus.i_pattern[N-1:1]};
              r_si     <= bus.i_pattern[0];
              r_exp    <= bus.i_expected;
              r_mask   <= bus.i_mask;
              r_cnt    <= '0;
              r_ready  <= 1'b0;
              r_mode   <= 1'b1;
              r_shift  <= 1'b1;
              r_state  <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_pat_sr <= {1'b0, r_pat_sr[N-1:1]};
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
              r_si    <= 1'b0;
              r_shift <= 1'b0;
              r_upd   <= 1'b1;
              r_state <= S_UPDATE;
            end else begin
              r_si <= r_pat_sr[0];
            end
          end
          S_UPDATE: begin
            r_upd   <= 1'b0;
            r_cap   <= 1'b1;
            r_state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            r_cap   <= 1'b0;
            r_shift <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_UNLOAD;
          end
          S_UNLOAD: begin
            r_resp_sr <= {bus.i_chain_so, r_resp_sr[N-1:1]};
            r_cnt     <= r_cnt + 1'b1;
            if (w_last) begin
              r_shift <= 1'b0;
              r_state <= S_COMPARE;
            end
          end
          S_COMPARE: begin
            r_response  <= r_resp_sr;
            r_fail_bits <= w_fail;
            r_pass      <= (w_fail == '0);
            if (r_pcnt != '1) r_pcnt <= r_pcnt + 1'b1;
            if (w_fail != '0 && r_fcnt != '1) r_fcnt <= r_fcnt + 1'b1;
            r_done  <= 1'b1;
            r_mode  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_shift <= 1'b0;
            r_upd   <= 1'b0;
            r_cap   <= 1'b0;
            r_si    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_ready         = r_ready;
  assign bus.o_extest_mode   = r_mode;
  assign bus.o_shift_en      = r_shift;
  assign bus.o_update_en     = r_upd;
  assign bus.o_capture_en    = r_cap;
  assign bus.o_chain_si      = r_si;
  assign bus.o_done          = r_done;
  assign bus.o_pass          = r_pass;
  assign bus.o_response      = r_response;
  assign bus.o_fail_bits     = r_fail_bits;
  assign bus.o_pattern_count = r_pcnt;
  assign bus.o_fail_count    = r_fcnt;
endmodule

// File: doc/extest_sequencer.md
Name: extest_sequencer

Overview:
- Controller that runs complete EXTEST patterns through the 8-cell boundary wrapper chain (4 input WBCs + 4 output WBCs).
- Per pattern it:
  - serially loads a stimulus vector into the chain;
  - issues one update cycle, then one capture cycle;
  - unloads the captured response;
  - compares the response against a masked expected value.
- Sits between the test host (or BIST controller) and extest_wrapper. It drives the wrapper's extest_mode, en and extest_scan_in, and observes extest_scan_out.

Parameters:
- N, 8, wrapper scan-chain length in bits.
- CNT_W, 16, width of the pattern and fail counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to run one pattern; accepted only when ready=1.
- abort  in  1  cancel the pattern in progress.
- pattern  in  N  stimulus vector; bit 0 is shifted first.
- expected  in  N  expected captured response.
- mask  in  N  per-bit compare enable (1 = compare).
- ready  out  1  sequencer idle; can accept start.
- extest_mode  out  1  puts the wrapper in EXTEST mode.
- shift_en  out  1  chain shift enable (drives the wrapper en).
- update_en  out  1  one-cycle update strobe.
- capture_en  out  1  one-cycle capture strobe.
- chain_si  out  1  serial data into the chain (extest_scan_in).
- chain_so  in  1  serial data from the chain (extest_scan_out); valid combinationally each cycle.
- done  out  1  one-cycle pulse when a pattern completes.
- pass  out  1  result of the last completed pattern.
- response  out  N  last unloaded response.
- fail_bits  out  N  (response ^ expected) & mask of the last completed pattern.
- pattern_count  out  CNT_W  completed patterns, saturating.
- fail_count  out  CNT_W  failed patterns, saturating.

Behaviour:
- Reset (async, active-high):
  - state goes to IDLE;
  - all outputs and internal registers are 0;
  - ready=0 while reset is high, and ready=1 in the first cycle after release.
- States: IDLE, LOAD, UPDATE, CAPTURE, UNLOAD, COMPARE. Bit counter is $clog2(N+1) bits wide.
- IDLE:
  - ready=1; extest_mode, shift_en, update_en, capture_en and chain_si are all 0.
  - start=1 at an edge latches pattern, expected and mask into shadow registers, clears the counter and moves to LOAD.
- LOAD (N cycles):
  - extest_mode=1, shift_en=1, chain_si = pat_sr[0].
  - Each edge shifts pat_sr right and increments the counter.
  - At the edge where counter == N-1, moves to UPDATE.
- UPDATE (1 cycle): extest_mode=1, update_en=1, shift_en=0. Then moves to CAPTURE.
- CAPTURE (1 cycle): extest_mode=1, capture_en=1. Then moves to UNLOAD.
- UNLOAD (N cycles):
  - extest_mode=1, shift_en=1, chain_si=0.
  - Each edge: resp_sr <= {chain_so, resp_sr[N-1:1]}. The first bit out ends in response bit 0.
  - After N edges, moves to COMPARE.
- COMPARE (1 cycle): extest_mode=1, all enables 0. On the exit edge it registers:
  - response, and fail_bits = (resp ^ expected) & mask;
  - pass = (fail_bits == 0);
  - pattern_count+1, and fail_count+1 if pass=0; both saturate at all-ones;
  - done=1 for exactly one cycle; state returns to IDLE.
- Latency: done rises at the (2N+3)th edge after the accepting edge, i.e. 19 for N=8.
- Back-to-back: start=1 during the done cycle (ready=1) is accepted, so there is no idle gap.
- abort:
  - In any state other than IDLE, abort at an edge goes to IDLE next cycle and deasserts all chain controls.
  - No done pulse; response, fail_bits, pass and counters are unchanged.
  - In IDLE, abort is ignored; abort and start together in IDLE means start is ignored.
- mask=0: pass=1 regardless of response.
- Input changes to pattern, expected or mask after acceptance have no effect on the running pattern.
- Reset mid-operation overrides everything (async), including clearing the counters.

Test Plan:
- Bench wrapper model: 8-bit shift register; on capture_en it loads a programmable capture value.
- Normal pass: model capture value 8'hA5; pattern=8'hA5, expected=8'hA5, mask=8'hFF.
  -> chain_si during LOAD is 1,0,1,0,0,1,0,1;
  -> update_en at cycle 9, capture_en at cycle 10;
  -> done at edge 19 with pass=1, fail_bits=0, response=8'hA5, pattern_count=1.
- Mismatch: model captures 8'h3C; expected=8'h3D, mask=8'hFF -> fail_bits=8'h01, pass=0, fail_count=1. Rerun with mask=8'hFE -> pass=1, fail_count stays 1.
- Abort: abort on the 3rd LOAD cycle.
  -> next cycle IDLE, ready=1, extest_mode=0, shift_en=0;
  -> no done; counters and response unchanged;
  -> a start in the following cycle runs normally.
- Back-to-back: start held high through the first done cycle.
  -> the second LOAD starts in the cycle after done;
  -> second done 19 edges later; pattern_count=2.
- Reset mid-UNLOAD: reset pulsed high -> all outputs 0 immediately (async), counters 0, ready=1 after release.
- Saturation (CNT_W=2): 5 failing patterns -> pattern_count=3 and fail_count=3, holding.
